// File: rtl/back_end_read_if.sv
// Cache back-end read bus: refill request from cache control, refill word
// strobe back into the line buffer, and the native read-only memory port.
interface back_end_read_if #(
  parameter int unsigned FE_ADDR_W  = 32,
  parameter int unsigned FE_DATA_W  = 32,
  parameter int unsigned WORD_OFF_W = 3
);
  localparam int unsigned FE_NBYTES = FE_DATA_W / 8;
  localparam int unsigned FE_BYTE_W = $clog2(FE_NBYTES);
  localparam int unsigned LINE_W    = FE_ADDR_W - FE_BYTE_W - WORD_OFF_W;

  logic                  replace_valid;
  logic [LINE_W-1:0]     replace_addr;
  logic                  replace;
  logic                  read_valid;
  logic [WORD_OFF_W-1:0] read_addr;
  logic [FE_DATA_W-1:0]  read_rdata;
  logic                  mem_valid;
  logic [FE_ADDR_W-1:0]  mem_addr;
  logic                  mem_ready;
  logic [FE_DATA_W-1:0]  mem_rdata;

  // Back-end side: answers refill requests and masters the memory port.
  modport master (
    input  replace_valid, replace_addr, mem_ready, mem_rdata,
    output replace, read_valid, read_addr, read_rdata, mem_valid, mem_addr
  );

  // Environment side: cache control plus memory.
  modport slave (
    output replace_valid, replace_addr, mem_ready, mem_rdata,
    input  replace, read_valid, read_addr, read_rdata, mem_valid, mem_addr
  );
endinterface

// File: rtl/back_end_read.sv
// Cache line refill engine: on a miss, fetches all words of the line from
// memory in ascending order and strobes each word into the cache line buffer.
module back_end_read #(
  parameter int unsigned FE_ADDR_W  = 32,
  parameter int unsigned FE_DATA_W  = 32,
  parameter int unsigned WORD_OFF_W = 3
) (
  input logic              clk,
  input logic              reset,
  back_end_read_if.master  bus
);
  localparam int unsigned FE_NBYTES = FE_DATA_W / 8;
  localparam int unsigned FE_BYTE_W = $clog2(FE_NBYTES);
  localparam int unsigned LINE_W    = FE_ADDR_W - FE_BYTE_W - WORD_OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_END
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_OFF_W-1:0] cnt_q, cnt_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic                  read_valid_q, read_valid_d;
  logic [WORD_OFF_W-1:0] read_addr_q, read_addr_d;
  logic [FE_DATA_W-1:0]  read_rdata_q, read_rdata_d;

  // State, word counter, line address and read-back registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      read_valid_q <= 1'b0;
      read_addr_q  <= '0;
      read_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      read_valid_q <= read_valid_d;
      read_addr_q  <= read_addr_d;
      read_rdata_q <= read_rdata_d;
    end
  end

  // Next-state logic: accept in IDLE, fetch words in LOAD, one END cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    read_valid_d = 1'b0;
    read_addr_d  = read_addr_q;
    read_rdata_d = read_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.replace_valid) begin
          line_d  = bus.replace_addr;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.mem_ready) begin
          read_valid_d = 1'b1;
          read_addr_d  = cnt_q;
          read_rdata_d = bus.mem_rdata;
          // Counter wraps to zero naturally on the last word of the line.
          cnt_d        = cnt_q + WORD_OFF_W'(1);
          if (cnt_q == '1) begin
            state_d = ST_END;
          end
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.replace    = (state_q != ST_IDLE);
  assign bus.mem_valid  = (state_q == ST_LOAD);
  assign bus.mem_addr   = FE_ADDR_W'({line_q, cnt_q}) << FE_BYTE_W;
  assign bus.read_valid = read_valid_q;
  assign bus.read_addr  = read_addr_q;
  assign bus.read_rdata = read_rdata_q;

endmodule

// File: tb/tb_back_end_read.sv
// Randomized bench for back_end_read against a transaction-level refill model.
module tb_back_end_read;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned WOW    = 3;
  localparam int unsigned NW     = 1 << WOW;
  localparam int unsigned NBYTES = DW / 8;
  localparam int unsigned LW     = AW - $clog2(NBYTES) - WOW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  back_end_read_if #(.FE_ADDR_W(AW), .FE_DATA_W(DW), .WORD_OFF_W(WOW)) bus ();

  back_end_read #(.FE_ADDR_W(AW), .FE_DATA_W(DW), .WORD_OFF_W(WOW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: one refill = a line address plus a count of delivered words.
  bit              m_active;
  longint unsigned m_line;
  int unsigned     m_word;
  bit              m_rv;
  longint unsigned m_raddr;
  longint unsigned m_rdata;
  bit              m_done;
  int unsigned     rv_count;
  int unsigned     replace_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_line   = 0;
    m_word   = 0;
    m_rv     = 1'b0;
    m_raddr  = 0;
    m_rdata  = 0;
    m_done   = 1'b0;
    rv_count = 0;
  endtask

  // Byte address of the word the model expects on the memory port.
  function automatic logic [63:0] exp_addr();
    longint unsigned a;
    a = (m_line * NW + longint'(m_word % NW)) * NBYTES;
    return 64'(32'(a));
  endfunction

  task automatic model_update(input bit rv, input logic [LW-1:0] ra,
                              input bit mr, input logic [DW-1:0] md);
    m_rv = 1'b0;
    if (!m_active) begin
      if (rv) begin
        m_active = 1'b1;
        m_line   = longint'(ra);
        m_word   = 0;
      end
    end else if (m_word == NW) begin
      m_active = 1'b0;
      m_done   = 1'b1;
    end else if (mr) begin
      m_rv    = 1'b1;
      m_raddr = longint'(m_word);
      m_rdata = longint'(md);
      m_word++;
    end
  endtask

  task automatic check_outputs();
    check("replace",    64'(bus.replace),    64'(m_active));
    check("mem_valid",  64'(bus.mem_valid),  64'(m_active && (m_word < NW)));
    check("mem_addr",   64'(bus.mem_addr),   exp_addr());
    check("read_valid", 64'(bus.read_valid), 64'(m_rv));
    check("read_addr",  64'(bus.read_addr),  m_raddr);
    check("read_rdata", 64'(bus.read_rdata), m_rdata);
    if (bus.read_valid === 1'b1) rv_count++;
    if (bus.replace === 1'b1) replace_cycles++;
    if (m_done) begin
      check("words_per_refill", 64'(rv_count), 64'(NW));
      rv_count = 0;
      m_done   = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic cycle(input bit rv, input logic [LW-1:0] ra,
                       input bit mr, input logic [DW-1:0] md);
    bus.replace_valid = rv;
    bus.replace_addr  = ra;
    bus.mem_ready     = mr;
    bus.mem_rdata     = md;
    @(posedge clk);
    model_update(rv, ra, mr, md);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] addr;
    reset             = 1'b0;
    bus.replace_valid = 1'b0;
    bus.replace_addr  = '0;
    bus.mem_ready     = 1'b0;
    bus.mem_rdata     = '0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Memory ready while idle must not produce words or start a refill.
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, DW'($urandom));
    check("idle_no_read_valid", 64'(rv_count), 64'd0);

    // Directed refill of line 0x123456 with memory always ready.
    replace_cycles = 0;
    cycle(1'b1, LW'(32'h123456), 1'b1, DW'($urandom));
    check("first_word_addr", 64'(bus.mem_addr), 64'h0246_8AC0);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, DW'($urandom));
    check("replace_high_cycles", 64'(replace_cycles), 64'd9);

    // Random refills, 30% ready duty, stray requests during refills.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 4) == 0, LW'($urandom), ($urandom % 10) < 3, DW'($urandom));
    end
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, ($urandom % 2) == 0, DW'($urandom));

    // Request held high continuously with a new address every cycle.
    for (int i = 0; i < 60; i++) cycle(1'b1, LW'($urandom), ($urandom % 2) == 0, DW'($urandom));
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1, DW'($urandom));

    // Asynchronous reset after the third word of a refill.
    addr = LW'($urandom);
    cycle(1'b1, addr, 1'b0, DW'($urandom));
    for (int i = 0; i < 40 && m_word < 3; i++) cycle(1'b0, '0, ($urandom % 2) == 0, DW'($urandom));
    check("pre_reset_read_addr", 64'(bus.read_addr), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    addr = LW'($urandom);
    cycle(1'b1, addr, 1'b1, DW'($urandom));
    check("post_reset_accept", 64'(bus.replace), 64'd1);
    for (int i = 0; i < int'(NW) + 4; i++) cycle(1'b0, '0, 1'b1, DW'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
